// File: rtl/trade_order_manager.sv
// Order manager behind the SMA signal stage: turns buy/sell pulses into single,
// position-limited orders, tracks fills, fill timeouts and a post-trade cooldown.
module trade_order_manager #(
  parameter int MAX_POS  = 4,
  parameter int COOLDOWN = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buy_signal,
  input  logic       sell_signal,
  input  logic [7:0] price_in,
  output logic       order_valid,
  input  logic       order_ready,
  output logic       order_side,
  output logic [7:0] order_price,
  output logic [7:0] order_id,
  input  logic       fill_valid,
  output logic [3:0] position,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] conflict_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int CD_W = $clog2(COOLDOWN + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
  localparam logic signed [3:0] POS_MAX = 4'(MAX_POS);
  localparam logic signed [3:0] POS_MIN = 4'(-MAX_POS);

  logic [1:0]        state, state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [CD_W-1:0]   cd_cnt;
  logic signed [3:0] pos_q;
  logic accept_buy, accept_sell, conflict, handshake, fill_hit, expired, cd_done;

  assign position = pos_q;

  always_comb begin
    accept_buy  = (state == S_IDLE) && buy_signal && !sell_signal && (pos_q < POS_MAX);
    accept_sell = (state == S_IDLE) && sell_signal && !buy_signal && (pos_q > POS_MIN);
    conflict    = (state == S_IDLE) && buy_signal && sell_signal;
    handshake   = (state == S_ISSUE) && order_valid && order_ready;
    fill_hit    = (state == S_WAIT) && fill_valid;
    // A fill arriving on the expiring edge takes priority over the timeout.
    expired     = (state == S_WAIT) && !fill_valid && (to_cnt == TO_LAST);
    cd_done     = (state == S_COOL) && (cd_cnt == CD_ONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_buy || accept_sell) state_nxt = S_ISSUE;
      S_ISSUE: if (handshake) state_nxt = S_WAIT;
      S_WAIT:  if (fill_hit || expired) state_nxt = S_COOL;
      S_COOL:  if (cd_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      order_valid  <= 1'b0;
      order_side   <= 1'b0;
      order_price  <= 8'd0;
      order_id     <= 8'd0;
      pos_q        <= 4'sd0;
      timeout_err  <= 1'b0;
      conflict_cnt <= 8'd0;
      to_cnt       <= '0;
      cd_cnt       <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);

      if (accept_buy || accept_sell) begin
        order_valid <= 1'b1;
        order_side  <= accept_buy;
        order_price <= price_in;
      end

      if (conflict && conflict_cnt != 8'hFF)
        conflict_cnt <= conflict_cnt + 8'd1;

      if (handshake) begin
        order_valid <= 1'b0;
        order_id    <= order_id + 8'd1;
        to_cnt      <= '0;
      end

      if (fill_hit) begin
        pos_q <= order_side ? pos_q + 4'sd1 : pos_q - 4'sd1;
      end else if (expired) begin
        timeout_err <= 1'b1;
      end else if (state == S_WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (fill_hit || expired)
        cd_cnt <= CD_INIT;
      else if (state == S_COOL)
        cd_cnt <= cd_cnt - CD_W'(1);
    end
  end

endmodule
